// File: rtl/vector_add_feeder.sv
`default_nettype none
// ============================================================================
// Module   : vector_add_feeder
// Brief    : Wrapper stage for the 16-lane fp32 vector adder. It pairs two
//            valid/ready operand streams, issues registered operand pairs to
//            the fixed-latency adder, and captures the results in a
//            first-word-fall-through FIFO that feeds a valid/ready output.
//            Credit accounting (FIFO occupancy plus results in flight) makes
//            sure no result ever arrives at a full FIFO.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            a_tdata/a_tvalid/a_tready     - operand A stream
//            b_tdata/b_tvalid/b_tready     - operand B stream
//            add_in_valid/add_in_a/add_in_b - adder issue side
//            add_out_valid/add_out_data    - adder result side
//            m_tdata/m_tvalid/m_tready     - result stream
//            inflight                      - issued pairs not yet returned
//            err                           - sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module vector_add_feeder #(
    parameter int DATA_W      = 512,
    parameter int ADD_LATENCY = 11,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_tdata,
    input  logic              a_tvalid,
    output logic              a_tready,
    input  logic [DATA_W-1:0] b_tdata,
    input  logic              b_tvalid,
    output logic              b_tready,
    output logic              add_in_valid,
    output logic [DATA_W-1:0] add_in_a,
    output logic [DATA_W-1:0] add_in_b,
    input  logic              add_out_valid,
    input  logic [DATA_W-1:0] add_out_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [CNT_W-1:0]  inflight,
    output logic              err
);

    localparam int c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_DRAIN_W = $clog2(ADD_LATENCY + 3);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(ADD_LATENCY + 1);
    localparam logic [CNT_W:0]       c_DEPTH_EXT  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]     c_DEPTH      = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] c_ST_DRAIN = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    logic [0:0]           r_state_q,     w_state_d;
    logic [c_DRAIN_W-1:0] r_drain_cnt_q, w_drain_cnt_d;
    logic [CNT_W-1:0]     r_inflight_q,  w_inflight_d;
    logic [CNT_W-1:0]     r_count_q,     w_count_d;
    logic [c_PTR_W-1:0]   r_wr_ptr_q,    w_wr_ptr_d;
    logic [c_PTR_W-1:0]   r_rd_ptr_q,    w_rd_ptr_d;
    logic                 r_err_q,       w_err_d;
    logic                 r_add_valid_q, w_add_valid_d;
    logic [DATA_W-1:0]    r_add_a_q,     w_add_a_d;
    logic [DATA_W-1:0]    r_add_b_q,     w_add_b_d;

    logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];

    logic                 w_run;
    logic [CNT_W:0]       w_occupancy;
    logic                 w_credit_ok;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_fire;
    logic                 w_result_bad;
    logic                 w_push;

    assign w_run       = (r_state_q == c_ST_RUN);
    // Every issued pair owns a FIFO slot until its result is popped.
    assign w_occupancy = {1'b0, r_count_q} + {1'b0, r_inflight_q};
    assign w_credit_ok = (w_occupancy < c_DEPTH_EXT);
    assign w_empty     = (r_count_q == '0);
    assign w_full      = (r_count_q == c_DEPTH);
    assign w_pop       = !w_empty && m_tready;
    assign w_fire      = w_run && a_tvalid && b_tvalid && w_credit_ok;

    // Results during DRAIN are stale adder contents and are silently dropped.
    // A push into a full FIFO is fine only when a pop frees the slot.
    assign w_result_bad = w_run && add_out_valid &&
                          ((r_inflight_q == '0) || (w_full && !w_pop));
    assign w_push       = w_run && add_out_valid && !w_result_bad;

    // Each side's ready waits on the other side's valid so both operands are
    // consumed together or not at all.
    assign a_tready = w_run && b_tvalid && w_credit_ok;
    assign b_tready = w_run && a_tvalid && w_credit_ok;

    assign add_in_valid = r_add_valid_q;
    assign add_in_a     = r_add_a_q;
    assign add_in_b     = r_add_b_q;
    assign m_tvalid     = !w_empty;
    assign m_tdata      = w_empty ? '0 : r_mem[r_rd_ptr_q];
    assign inflight     = r_inflight_q;
    assign err          = r_err_q;

    always_comb begin
        w_state_d     = r_state_q;
        w_drain_cnt_d = r_drain_cnt_q;
        if (!w_run) begin
            if (r_drain_cnt_q == c_DRAIN_LAST) begin
                w_state_d = c_ST_RUN;
            end else begin
                w_drain_cnt_d = r_drain_cnt_q + c_DRAIN_W'(1);
            end
        end

        w_add_valid_d = w_fire;
        w_add_a_d     = w_fire ? a_tdata : r_add_a_q;
        w_add_b_d     = w_fire ? b_tdata : r_add_b_q;

        w_inflight_d = r_inflight_q;
        case ({w_fire, w_push})
            2'b10:   w_inflight_d = r_inflight_q + CNT_W'(1);
            2'b01:   w_inflight_d = r_inflight_q - CNT_W'(1);
            default: w_inflight_d = r_inflight_q;
        endcase

        w_count_d = r_count_q;
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + CNT_W'(1);
            2'b01:   w_count_d = r_count_q - CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase

        // Power-of-two depth: pointers wrap by natural overflow.
        w_wr_ptr_d = w_push ? r_wr_ptr_q + c_PTR_W'(1) : r_wr_ptr_q;
        w_rd_ptr_d = w_pop  ? r_rd_ptr_q + c_PTR_W'(1) : r_rd_ptr_q;

        w_err_d = r_err_q || w_result_bad;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= c_ST_DRAIN;
            r_drain_cnt_q <= '0;
            r_inflight_q  <= '0;
            r_count_q     <= '0;
            r_wr_ptr_q    <= '0;
            r_rd_ptr_q    <= '0;
            r_err_q       <= 1'b0;
            r_add_valid_q <= 1'b0;
            r_add_a_q     <= '0;
            r_add_b_q     <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_drain_cnt_q <= w_drain_cnt_d;
            r_inflight_q  <= w_inflight_d;
            r_count_q     <= w_count_d;
            r_wr_ptr_q    <= w_wr_ptr_d;
            r_rd_ptr_q    <= w_rd_ptr_d;
            r_err_q       <= w_err_d;
            r_add_valid_q <= w_add_valid_d;
            r_add_a_q     <= w_add_a_d;
            r_add_b_q     <= w_add_b_d;
        end
    end

    // Storage needs no reset: the empty count gates what is visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr_q] <= add_out_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_add_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_add_feeder
// Brief    : Self-checking bench for vector_add_feeder with a behavioural
//            11-cycle fp32 vector adder, table-driven lane vectors and
//            directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_add_feeder;

    localparam int DATA_W      = 512;
    localparam int ADD_LATENCY = 11;
    localparam int FIFO_DEPTH  = 16;
    localparam int CNT_W       = 5;
    localparam int LANES       = 16;
    localparam int N_TBL       = 7;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] a_tdata = '0;
    logic              a_tvalid = 1'b0;
    logic              a_tready;
    logic [DATA_W-1:0] b_tdata = '0;
    logic              b_tvalid = 1'b0;
    logic              b_tready;
    logic              add_in_valid;
    logic [DATA_W-1:0] add_in_a;
    logic [DATA_W-1:0] add_in_b;
    logic              add_out_valid;
    logic [DATA_W-1:0] add_out_data;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [CNT_W-1:0]  inflight;
    logic              err;

    vector_add_feeder #(
        .DATA_W      (DATA_W),
        .ADD_LATENCY (ADD_LATENCY),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_tdata       (a_tdata),
        .a_tvalid      (a_tvalid),
        .a_tready      (a_tready),
        .b_tdata       (b_tdata),
        .b_tvalid      (b_tvalid),
        .b_tready      (b_tready),
        .add_in_valid  (add_in_valid),
        .add_in_a      (add_in_a),
        .add_in_b      (add_in_b),
        .add_out_valid (add_out_valid),
        .add_out_data  (add_out_data),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .inflight      (inflight),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [DATA_W-1:0] act,
                           input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- fp32 helpers (normals and zero only) ----------------
    function automatic logic [63:0] f32_to_f64(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return {x[31], 63'd0};
        e = {3'b000, x[30:23]} + 11'd896;
        return {x[31], e, x[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] f64_to_f32(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] to_f32(input real r);
        return f64_to_f32($realtobits(r));
    endfunction

    function automatic logic [DATA_W-1:0] vec_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        real s;
        r = '0;
        for (int l = 0; l < LANES; l++) begin
            s = $bitstoreal(f32_to_f64(a[l*32 +: 32])) +
                $bitstoreal(f32_to_f64(b[l*32 +: 32]));
            r[l*32 +: 32] = to_f32(s);
        end
        return r;
    endfunction

    // ---------------- behavioural adder: 11 cycles, no reset ----------------
    logic [ADD_LATENCY-1:0] pv = '0;
    logic [DATA_W-1:0]      pd [ADD_LATENCY];
    logic                   inj_v = 1'b0;
    logic [DATA_W-1:0]      inj_d = '0;

    always @(posedge clk) begin
        pv    <= {pv[ADD_LATENCY-2:0], add_in_valid};
        pd[0] <= vec_add(add_in_a, add_in_b);
        for (int i = 1; i < ADD_LATENCY; i++) pd[i] <= pd[i-1];
    end

    assign add_out_valid = pv[ADD_LATENCY-1] | inj_v;
    assign add_out_data  = inj_v ? inj_d : pd[ADD_LATENCY-1];

    // ---------------- stream monitor / scoreboard ----------------
    int                fire_cnt = 0;
    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] sb_exp;

    always @(posedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            check_i("pair_handshake", int'(a_tvalid && a_tready), int'(b_tvalid && b_tready));
            if (a_tvalid && a_tready && b_tvalid && b_tready) begin
                fire_cnt++;
                sb.push_back(vec_add(a_tdata, b_tdata));
                n_checks++;
                if (sb.size() > FIFO_DEPTH) begin
                    n_errors++;
                    $display("FAIL credit_bound: occupancy %0d exceeds %0d", sb.size(), FIFO_DEPTH);
                end
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL result_order: unexpected result %0h", m_tdata);
                end else begin
                    sb_exp = sb.pop_front();
                    check_v("result_order", m_tdata, sb_exp);
                end
            end
        end
    end

    // ---------------- lane table: a + b = sum, hand computed ----------------
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } lane_vec_t;

    lane_vec_t tbl [N_TBL];

    task automatic run_vec(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input logic [DATA_W-1:0] exp);
        int k;
        int f0;
        f0 = fire_cnt;
        @(negedge clk);
        a_tdata  = a;
        b_tdata  = b;
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        #1;
        k = 0;
        while (!(a_tready && b_tready) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL vec_ready_timeout: readies low for %0d cycles, required high", k);
            a_tvalid = 1'b0;
            b_tvalid = 1'b0;
            return;
        end
        @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        check_i("vec_one_fire", fire_cnt - f0, 1);
        check_i("vec_add_in_valid", int'(add_in_valid), 1);
        check_v("vec_add_in_a", add_in_a, a);
        check_v("vec_add_in_b", add_in_b, b);
        check_i("vec_inflight", int'(inflight), 1);
        k = 1;
        while (!m_tvalid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_i("vec_latency", k, ADD_LATENCY + 2);
        check_v("vec_m_tdata", m_tdata, exp);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] va, vb, ve;
        int f0, seen;

        tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40400000}; //  1.0 + 2.0  = 3.0
        tbl[1] = '{32'h3F000000, 32'h3E800000, 32'h3F400000}; //  0.5 + 0.25 = 0.75
        tbl[2] = '{32'h40400000, 32'h40A00000, 32'h41000000}; //  3.0 + 5.0  = 8.0
        tbl[3] = '{32'hBF800000, 32'h3F800000, 32'h00000000}; // -1.0 + 1.0  = 0.0
        tbl[4] = '{32'h41200000, 32'h40C00000, 32'h41800000}; // 10.0 + 6.0  = 16.0
        tbl[5] = '{32'h3FC00000, 32'h40200000, 32'h40800000}; //  1.5 + 2.5  = 4.0
        tbl[6] = '{32'hC0000000, 32'h3F000000, 32'hBFC00000}; // -2.0 + 0.5  = -1.5

        // ---- reset state, with both operands offered throughout ----
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        repeat (3) @(negedge clk);
        check_i("rst_add_in_valid", int'(add_in_valid), 0);
        check_v("rst_add_in_a", add_in_a, '0);
        check_v("rst_add_in_b", add_in_b, '0);
        check_i("rst_m_tvalid", int'(m_tvalid), 0);
        check_v("rst_m_tdata", m_tdata, '0);
        check_i("rst_readies", int'({a_tready, b_tready}), 0);
        check_i("rst_inflight", int'(inflight), 0);
        check_i("rst_err", int'(err), 0);

        rst_n = 1'b1;
        #1;
        for (int i = 0; i < ADD_LATENCY + 2; i++) begin
            check_i("drain_readies", int'({a_tready, b_tready}), 0);
            @(negedge clk);
            #1;
        end
        check_i("run_readies", int'({a_tready, b_tready}), 3);
        @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        #1;
        check_i("first_fire_cycle14", fire_cnt, 1);
        repeat (20) @(negedge clk);

        // ---- table-driven vectors; vector 0 is 1.0 + 2.0 on every lane ----
        for (int i = 0; i < N_TBL + 1; i++) begin
            for (int l = 0; l < LANES; l++) begin
                int e;
                e = (i == 0) ? 0 : (i + l) % N_TBL;
                va[l*32 +: 32] = tbl[e].a;
                vb[l*32 +: 32] = tbl[e].b;
                ve[l*32 +: 32] = tbl[e].sum;
            end
            run_vec(va, vb, ve);
        end

        // ---- lone A valid is never consumed ----
        f0 = fire_cnt;
        @(negedge clk);
        a_tvalid = 1'b1;
        b_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_i("lone_a_tready", int'(a_tready), 0);
            @(negedge clk);
        end
        check_i("lone_no_fire", fire_cnt - f0, 0);
        b_tvalid = 1'b1;
        @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        @(negedge clk);
        check_i("lone_then_one_fire", fire_cnt - f0, 1);
        repeat (20) @(negedge clk);

        // ---- backpressure: credits cap issue at FIFO_DEPTH ----
        f0 = fire_cnt;
        m_tready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            for (int l = 0; l < LANES; l++) begin
                a_tdata[l*32 +: 32] = to_f32(real'(c * 16 + l));
                b_tdata[l*32 +: 32] = 32'h3F800000;
            end
            a_tvalid = 1'b1;
            b_tvalid = 1'b1;
            @(negedge clk);
        end
        #1;
        check_i("bp_fire_count", fire_cnt - f0, FIFO_DEPTH);
        check_i("bp_readies_low", int'({a_tready, b_tready}), 0);
        check_i("bp_inflight", int'(inflight), 0);
        check_i("bp_err", int'(err), 0);
        check_i("bp_m_tvalid", int'(m_tvalid), 1);
        m_tready = 1'b1;
        repeat (10) @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        check_i("bp_issue_resumes", int'(fire_cnt - f0 > FIFO_DEPTH), 1);
        repeat (30) @(negedge clk);
        check_i("bp_drained", sb.size(), 0);
        check_i("bp_m_tvalid_low", int'(m_tvalid), 0);

        // ---- reset with 5 pairs in flight; DRAIN swallows their results ----
        f0 = fire_cnt;
        @(negedge clk);
        a_tdata  = {LANES{32'h3F800000}};
        b_tdata  = {LANES{32'h3F800000}};
        a_tvalid = 1'b1;
        b_tvalid = 1'b1;
        repeat (5) @(negedge clk);
        a_tvalid = 1'b0;
        b_tvalid = 1'b0;
        check_i("mid_fires", fire_cnt - f0, 5);
        check_i("mid_inflight", int'(inflight), 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_i("mid_rst_inflight", int'(inflight), 0);
        check_i("mid_rst_add_in_valid", int'(add_in_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (add_out_valid) seen++;
            check_i("mid_drain_state", int'({err, m_tvalid, inflight}), 0);
        end
        check_i("mid_late_results_seen", seen, 5);
        for (int l = 0; l < LANES; l++) begin
            va[l*32 +: 32] = tbl[2].a;
            vb[l*32 +: 32] = tbl[2].b;
            ve[l*32 +: 32] = tbl[2].sum;
        end
        run_vec(va, vb, ve);
        repeat (3) @(negedge clk);

        // ---- spurious adder result with nothing in flight ----
        check_i("inj_pre_inflight", int'(inflight), 0);
        inj_d = {LANES{32'h12345678}};
        inj_v = 1'b1;
        @(negedge clk);
        inj_v = 1'b0;
        check_i("inj_err_set", int'(err), 1);
        check_i("inj_m_tvalid", int'(m_tvalid), 0);
        check_i("inj_inflight", int'(inflight), 0);
        repeat (5) @(negedge clk);
        check_i("inj_err_sticky", int'(err), 1);
        check_i("inj_m_tvalid_later", int'(m_tvalid), 0);

        // ---- only reset clears err ----
        rst_n = 1'b0;
        #1;
        check_i("final_rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_i("final_err_low", int'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
